state_stream_tx: RTL
====================

Name: state_stream_tx

Overview:
- Transmit end of the Conway frame path.
- Accepts one complete next-generation state frame, one bit per cell, in a single handshake.
- Latches the frame and the colour pair, then serialises it as an AXI4-Stream master, one colour pixel per beat in row-major order.
- Marks start of frame with TUSER and end of frame with TLAST; it is the streaming counterpart of the frame-capture receiver.

Parameters:
- DWIDTH, 32, pixel/colour width in bits (TDATA width).
- WIDTH, 32, cells per row.
- HEIGHT, 32, rows per frame.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alive_color  in  DWIDTH  colour emitted for a live cell.
- dead_color  in  DWIDTH  colour emitted for a dead cell.
- frame_states  in  WIDTH*HEIGHT  flat state vector; bit i = cell (row i/WIDTH, col i%WIDTH), 1 = alive.
- frame_valid  in  1  frame_states and colours are valid.
- frame_ready  out  1  block can accept a frame.
- frame_done  out  1  one-cycle pulse after the final beat is transferred.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA  out  DWIDTH  pixel colour.
- M_AXIS_TLAST  out  1  high on the last pixel of the frame (index WIDTH*HEIGHT-1).
- M_AXIS_TUSER  out  1  high on the first pixel of the frame (index 0).

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; pixel counter = 0.
  - TVALID, TLAST, TUSER, frame_done = 0; TDATA = 0.
  - frame_ready = 0 while rst is high and 1 in IDLE after release.
  - Internal frame and colour registers are cleared to 0.
- Counter:
  - Width is clog2(WIDTH*HEIGHT), minimum 1.
  - Counts 0..WIDTH*HEIGHT-1 with no wrap inside a frame.
  - It is reset to 0 on frame acceptance.
- FSM IDLE:
  - frame_ready = 1, TVALID = 0.
  - On frame_valid & frame_ready at edge N, register frame_states, alive_color and dead_color.
  - Set counter = 0 and go to SEND.
  - TVALID is 1 from cycle N+1 with pixel 0 and TUSER = 1.
- FSM SEND:
  - frame_ready = 0; frame_valid is ignored.
  - TDATA = stored_state[cnt] ? stored_alive : stored_dead, registered.
  - TUSER = (cnt == 0); TLAST = (cnt == WIDTH*HEIGHT-1).
  - On TVALID & TREADY with cnt < last: cnt++ and the next pixel is presented the following cycle. Throughput is 1 beat/cycle while TREADY is held high.
  - On TVALID & TREADY with cnt == last: go to IDLE next cycle, drop TVALID/TLAST, and pulse frame_done for exactly one cycle.
  - frame_ready returns to 1 in that same cycle; there is no same-cycle re-accept on the last beat.
- Backpressure:
  - While TVALID = 1 and TREADY = 0, TDATA, TLAST, TUSER and cnt are held stable.
  - TVALID never deasserts before its transfer (AXI rule).
- Input isolation:
  - Changes to frame_states, alive_color or dead_color during SEND do not affect the frame in flight; the values latched at accept are used.
- Frame length:
  - One frame is exactly WIDTH*HEIGHT beats.
  - TUSER and TLAST are never both high unless WIDTH*HEIGHT == 1, in which case both are high on the single beat.
- Reset mid-frame:
  - Transmission aborts immediately, with TVALID = 0 asynchronously.
  - No TLAST or frame_done is emitted.
  - After release the block is in IDLE with frame_ready = 1.
- Minimum frame period: WIDTH*HEIGHT + 1 cycles (one IDLE cycle between frames).

Test Plan:
- WIDTH=4, HEIGHT=2, DWIDTH=32, TREADY held at 1:
  - Stimulus: frame_states = 8'b1010_0101, alive = 32'hFFFFFFFF, dead = 32'h00000000.
  - Required: 8 consecutive beats in order FF..,00,FF..,00,00,FF..,00,FF.., i.e. bit0 first.
  - Required: TUSER only on beat 0, TLAST only on beat 7, frame_done one cycle after beat 7, frame_ready high the following cycle.
- Backpressure, same frame:
  - Stimulus: TREADY low for 3 cycles at beat 2 and again at beat 7.
  - Required: TDATA/TLAST held stable while stalled, TVALID stays 1, 8 transfers total, data order unchanged.
- Input isolation:
  - Stimulus: change alive_color to 32'h12345678 and invert frame_states at beat 3.
  - Required: all 8 beats match the values latched at accept.
- Back-to-back frames:
  - Stimulus: frame_valid held high with two different frames.
  - Required: second accept occurs exactly one IDLE cycle after frame_done; 16 beats with two TUSER and two TLAST.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously (between edges) during beat 4.
  - Required: TVALID falls immediately, no TLAST or frame_done; after release frame_ready = 1 and a new frame restarts at pixel 0 with TUSER = 1.
- Default parameters (32x32), random TREADY:
  - Required: exactly 1024 beats per frame, TLAST on beat 1023, pixel colours match the reference model bit-for-bit.

Source files
------------

// File: rtl/state_stream_tx.sv
// Transmit end of the Conway frame path: latches one full state frame plus its
// colour pair, then streams one colour pixel per AXI4-Stream beat, row-major.
module state_stream_tx #(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DWIDTH-1:0]         alive_color,
  input  logic [DWIDTH-1:0]         dead_color,
  input  logic [WIDTH*HEIGHT-1:0]   frame_states,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  output logic                      frame_done,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic [DWIDTH-1:0]         M_AXIS_TDATA,
  output logic                      M_AXIS_TLAST,
  output logic                      M_AXIS_TUSER
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [NPIX-1:0]   st_q;
  logic [DWIDTH-1:0] alive_q;
  logic [DWIDTH-1:0] dead_q;

  assign cnt_nxt = cnt + 1'b1;

  // Ready is gated by rst so it reads 0 during reset and 1 the moment IDLE is released.
  assign frame_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      st_q          <= '0;
      alive_q       <= '0;
      dead_q        <= '0;
      frame_done    <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TUSER  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_valid) begin
            // Pixel 0 comes straight from the inputs so TVALID rises the cycle after accept.
            st_q          <= frame_states;
            alive_q       <= alive_color;
            dead_q        <= dead_color;
            cnt           <= '0;
            state         <= SEND;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= frame_states[0] ? alive_color : dead_color;
            M_AXIS_TUSER  <= 1'b1;
            M_AXIS_TLAST  <= (NPIX == 1);
          end
        end
        SEND: begin
          if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (cnt == LAST) begin
              state         <= IDLE;
              M_AXIS_TVALID <= 1'b0;
              M_AXIS_TLAST  <= 1'b0;
              M_AXIS_TUSER  <= 1'b0;
              frame_done    <= 1'b1;
            end else begin
              cnt          <= cnt_nxt;
              M_AXIS_TDATA <= st_q[cnt_nxt] ? alive_q : dead_q;
              M_AXIS_TUSER <= 1'b0;
              M_AXIS_TLAST <= (cnt_nxt == LAST);
            end
          end
        end
      endcase
    end
  end
endmodule
